// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: I/O register map, FSM state
// encoding and the layout of the registered write-back bundle.
package mem_defs;

  localparam logic [9:0] IO_LED     = 10'h000;
  localparam logic [9:0] IO_SEG     = 10'h004;
  localparam logic [9:0] IO_SW      = 10'h010;
  localparam logic [9:0] IO_KEY     = 10'h014;
  localparam logic [9:0] IO_SW_CONF = 10'h018;

  localparam int WB_CTRL_W   = 2;
  localparam int WB_RD_W     = 5;
  localparam int WB_DATA_W   = 32;
  localparam int WB_BUNDLE_W = WB_CTRL_W + WB_RD_W + 2 * WB_DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    IO_WAIT = 2'd2
  } memState_t;

  typedef struct packed {
    logic                 regWrite;
    logic                 memToReg;
    logic [WB_RD_W-1:0]   rdAddr;
    logic [WB_DATA_W-1:0] aluResult;
    logic [WB_DATA_W-1:0] rdata;
  } wbBundle_t;

  // Single-cycle I/O reads only; the confirmed switch read goes through the FSM.
  function automatic logic [WB_DATA_W-1:0] ioReadData(input logic [9:0]  off,
                                                      input logic [11:0] sw,
                                                      input logic [3:0]  key);
    logic [WB_DATA_W-1:0] v;
    v = '0;
    case (off)
      IO_SW:   v = {20'b0, sw};
      IO_KEY:  v = {28'b0, key};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous push button followed by an edge
// register; o_rise is a one-cycle pulse on each synchronized rising edge.
module btn_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic i_btn,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register: RAM word loads/stores, memory-mapped
// LED/7-seg/switch/keypad I/O, and a blocking switch read released by a button.
module mem_wb_stage
  import mem_defs::*;
#(
  parameter logic [31:0] IO_BASE = 32'hFFFF_FC00
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_MemtoReg,
  input  logic        MEM_RegWrite,
  input  logic        MEM_ioRead,
  input  logic        MEM_ioWrite,
  input  logic [4:0]  MEM_rd_addr,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_rs2_v,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        conf_btn,
  input  logic [11:0] switch_data,
  input  logic [3:0]  key_data,
  output logic [15:0] led_out,
  output logic [31:0] seg_out,
  output logic        mem_stall,
  output logic        WB_RegWrite,
  output logic        WB_MemtoReg,
  output logic [4:0]  WB_rd_addr,
  output logic [31:0] WB_ALUResult,
  output logic [31:0] WB_rdata
);

  memState_t r_state;
  wbBundle_t r_wb;
  logic [15:0] r_led;
  logic [31:0] r_seg;

  logic        w_isIo;
  logic [9:0]  w_ioOff;
  logic        w_ramRead;
  logic        w_ramWrite;
  logic        w_ioRd;
  logic        w_ioWr;
  logic        w_confRd;
  logic        w_btnRise;
  logic        w_stall;
  logic [31:0] w_wbRdata;
  wbBundle_t   w_nextWb;

  btn_sync_edge u_btn (
    .clk    (clk),
    .rstn   (rstn),
    .i_btn  (conf_btn),
    .o_rise (w_btnRise)
  );

  // RAM controls never act on the I/O window; read wins over write on both paths.
  assign w_isIo     = (MEM_ALUResult[31:10] == IO_BASE[31:10]);
  assign w_ioOff    = MEM_ALUResult[9:0];
  assign w_ramRead  = MEM_MemRead & ~w_isIo;
  assign w_ramWrite = MEM_MemWrite & ~MEM_MemRead & ~w_isIo;
  assign w_ioRd     = MEM_ioRead & w_isIo;
  assign w_ioWr     = MEM_ioWrite & ~MEM_ioRead & w_isIo;
  assign w_confRd   = w_ioRd & (w_ioOff == IO_SW_CONF);

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      IDLE:    w_stall = w_ramRead | w_confRd;
      LOAD:    w_stall = 1'b0;
      IO_WAIT: w_stall = ~w_btnRise;
      default: w_stall = 1'b0;
    endcase
  end

  always_comb begin
    w_wbRdata = '0;
    case (r_state)
      LOAD:    w_wbRdata = dmem_rdata;
      IO_WAIT: w_wbRdata = {20'b0, switch_data};
      default: w_wbRdata = w_ioRd ? ioReadData(w_ioOff, switch_data, key_data) : '0;
    endcase
  end

  // A stalled cycle pushes a bubble so WB never sees a half-finished access.
  always_comb begin
    w_nextWb = '0;
    if (!w_stall) begin
      w_nextWb.regWrite  = MEM_RegWrite;
      w_nextWb.memToReg  = MEM_MemtoReg;
      w_nextWb.rdAddr    = MEM_rd_addr;
      w_nextWb.aluResult = MEM_ALUResult;
      w_nextWb.rdata     = w_wbRdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_wb    <= '0;
    end else begin
      r_wb <= w_nextWb;
      case (r_state)
        IDLE: begin
          if (w_ramRead)     r_state <= LOAD;
          else if (w_confRd) r_state <= IO_WAIT;
        end
        LOAD:    r_state <= IDLE;
        IO_WAIT: if (w_btnRise) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_led <= '0;
      r_seg <= '0;
    end else if (w_ioWr && r_state == IDLE) begin
      case (w_ioOff)
        IO_LED:  r_led <= MEM_rs2_v[15:0];
        IO_SEG:  r_seg <= MEM_rs2_v;
        default: ;
      endcase
    end
  end

  assign dmem_addr    = MEM_ALUResult;
  assign dmem_wdata   = MEM_rs2_v;
  assign dmem_we      = (r_state == IDLE) & w_ramWrite;
  assign mem_stall    = w_stall;
  assign led_out      = r_led;
  assign seg_out      = r_seg;
  assign WB_RegWrite  = r_wb.regWrite;
  assign WB_MemtoReg  = r_wb.memToReg;
  assign WB_rd_addr   = r_wb.rdAddr;
  assign WB_ALUResult = r_wb.aluResult;
  assign WB_rdata     = r_wb.rdata;

endmodule
